// File: rtl/cache_bus_pkg.sv
// Shared bus-side types for the L1 MESI controller and its snoop responder:
// bus ops, snoop results, responder states and the address-to-snoop model.
package cache_bus_pkg;

    typedef enum logic [1:0] {
        BUSRD   = 2'd0,
        BUSRDX  = 2'd1,
        BUSUPGR = 2'd2,
        FLUSH   = 2'd3
    } bus_op_t;

    typedef enum logic [1:0] {
        NOHIT = 2'd0,
        HIT   = 2'd1,
        HITM  = 2'd2
    } snoop_res_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNOOP = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } resp_state_t;

    // The modelled "other caches" answer purely from the low line-address bits.
    function automatic snoop_res_t snoop_of_addr(input logic [1:0] addr);
        snoop_res_t res;
        case (addr)
            2'b00:   res = HIT;
            2'b01:   res = HITM;
            default: res = NOHIT;
        endcase
        return res;
    endfunction

    // Latencies live in a 4-bit counter; zero would never expire, so it becomes 1.
    function automatic logic [3:0] clamp_lat(input int lat);
        logic [3:0] v;
        if (lat < 1)
            v = 4'd1;
        else if (lat > 15)
            v = 4'd15;
        else
            v = lat[3:0];
        return v;
    endfunction

endpackage

// File: rtl/cache_resp_lat_cntr.sv
// Loadable 4-bit down-counter timing the responder's WAIT state.
// expire flags the last cycle of the loaded interval (value == 1).
module cache_resp_lat_cntr (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic [3:0] value,
    output logic       expire
);

    logic [3:0] value_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_reg <= 4'd0;
        end else if (load) begin
            value_reg <= load_val;
        end else if (dec && (value_reg != 4'd0)) begin
            value_reg <= value_reg - 4'd1;
        end
    end

    assign value  = value_reg;
    assign expire = (value_reg == 4'd1);

endmodule

// File: rtl/cache_snoop_responder.sv
// Bus endpoint for the L1 MESI controller: snoops, drives the shared (C) line
// and completes after a modelled latency. Optional statistics via CACHE_SNOOP_STATS_EN.
module cache_snoop_responder
    import cache_bus_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MEM_LAT  = 4,
    parameter int HITM_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              req_valid,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              snoop_valid,
    output logic [1:0]        snoop_res,
    output logic              c_out,
    output logic              done_valid,
    output logic [1:0]        done_op,
    output logic              busy
`ifdef CACHE_SNOOP_STATS_EN
    ,
    output logic [CNT_W-1:0]  busrd_cnt,
    output logic [CNT_W-1:0]  busrdx_cnt,
    output logic [CNT_W-1:0]  busupgr_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  hitm_cnt
`endif
);

    localparam logic [3:0] MEM_LAT_C  = clamp_lat(MEM_LAT);
    localparam logic [3:0] HITM_LAT_C = clamp_lat(HITM_LAT);

    resp_state_t       state_reg;
    bus_op_t           op_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              req_ready_reg;
    logic              busy_reg;
    logic              snoop_valid_reg;
    snoop_res_t        snoop_res_reg;
    logic              c_out_reg;
    logic              done_valid_reg;
    bus_op_t           done_op_reg;

    bus_op_t    req_op_in;
    snoop_res_t req_res;
    snoop_res_t cap_res;
    logic       accept;

    assign req_op_in = bus_op_t'(req_op);
    assign req_res   = snoop_of_addr(req_addr[1:0]);
    assign cap_res   = snoop_of_addr(addr_reg[1:0]);
    assign accept    = req_valid && req_ready_reg;

    // Only the low bits steer the snoop model; the rest is kept as part of the captured request.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_reg[ADDR_W-1:2];

    // Latency counter is loaded on the SNOOP cycle and counts down through WAIT.
    logic       cnt_load;
    logic [3:0] cnt_load_val;
    logic       cnt_dec;
    logic [3:0] cnt_value;
    logic       cnt_expire;

    assign cnt_load     = (state_reg == SNOOP) && (op_reg != BUSUPGR);
    assign cnt_load_val = ((op_reg != FLUSH) && (cap_res == HITM)) ? HITM_LAT_C : MEM_LAT_C;
    assign cnt_dec      = (state_reg == WAIT);

    cache_resp_lat_cntr u_lat_cntr (
        .clk      (clk),
        .rst      (rstb),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .value    (cnt_value),
        .expire   (cnt_expire)
    );

    logic unused_cnt_value;
    assign unused_cnt_value = ^cnt_value;

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state_reg       <= IDLE;
            op_reg          <= BUSRD;
            addr_reg        <= '0;
            req_ready_reg   <= 1'b1;
            busy_reg        <= 1'b0;
            snoop_valid_reg <= 1'b0;
            snoop_res_reg   <= NOHIT;
            c_out_reg       <= 1'b0;
            done_valid_reg  <= 1'b0;
            done_op_reg     <= BUSRD;
        end else begin
            // Pulse outputs default back to zero every cycle.
            snoop_valid_reg <= 1'b0;
            snoop_res_reg   <= NOHIT;
            c_out_reg       <= 1'b0;
            done_valid_reg  <= 1'b0;
            done_op_reg     <= BUSRD;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg        <= req_op_in;
                        addr_reg      <= req_addr;
                        state_reg     <= SNOOP;
                        req_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        if (req_op_in != FLUSH) begin
                            snoop_valid_reg <= 1'b1;
                            snoop_res_reg   <= req_res;
                            c_out_reg       <= (req_res != NOHIT);
                        end
                    end
                end
                SNOOP: begin
                    if (op_reg == BUSUPGR) begin
                        state_reg      <= DONE;
                        done_valid_reg <= 1'b1;
                        done_op_reg    <= op_reg;
                    end else begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_expire) begin
                        state_reg      <= DONE;
                        done_valid_reg <= 1'b1;
                        done_op_reg    <= op_reg;
                    end
                end
                DONE: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                end
                default: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_reg;
    assign busy        = busy_reg;
    assign snoop_valid = snoop_valid_reg;
    assign snoop_res   = snoop_res_reg;
    assign c_out       = c_out_reg;
    assign done_valid  = done_valid_reg;
    assign done_op     = done_op_reg;

`ifdef CACHE_SNOOP_STATS_EN
    logic [CNT_W-1:0] op_cnt [4];

    // One saturating completion counter per bus op, indexed by the op encoding.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gen_op_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or posedge rstb) begin
                if (rstb) begin
                    cnt_reg <= '0;
                end else if (done_valid_reg && (done_op_reg == 2'(gi)) && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
            assign op_cnt[gi] = cnt_reg;
        end
    endgenerate

    logic [CNT_W-1:0] hitm_cnt_reg;

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            hitm_cnt_reg <= '0;
        end else if (snoop_valid_reg && (snoop_res_reg == HITM) && (hitm_cnt_reg != '1)) begin
            hitm_cnt_reg <= hitm_cnt_reg + CNT_W'(1);
        end
    end

    assign busrd_cnt   = op_cnt[0];
    assign busrdx_cnt  = op_cnt[1];
    assign busupgr_cnt = op_cnt[2];
    assign flush_cnt   = op_cnt[3];
    assign hitm_cnt    = hitm_cnt_reg;
`endif

endmodule

// File: tb/tb_cache_snoop_responder.sv
// Self-checking bench for cache_snoop_responder: vector table, random ops vs a
// latency/snoop model, reset abort, and counters when CACHE_SNOOP_STATS_EN is set.
module tb_cache_snoop_responder;

    localparam int ADDR_W   = 32;
    localparam int MEM_LAT  = 4;
    localparam int HITM_LAT = 2;
    localparam int CNT_W    = 16;

    logic              clk = 1'b0;
    logic              rstb;
    logic              req_valid;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              snoop_valid;
    logic [1:0]        snoop_res;
    logic              c_out;
    logic              done_valid;
    logic [1:0]        done_op;
    logic              busy;
`ifdef CACHE_SNOOP_STATS_EN
    logic [CNT_W-1:0]  busrd_cnt, busrdx_cnt, busupgr_cnt, flush_cnt, hitm_cnt;
`endif

    always #5 clk = ~clk;

    cache_snoop_responder #(
        .ADDR_W   (ADDR_W),
        .MEM_LAT  (MEM_LAT),
        .HITM_LAT (HITM_LAT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .snoop_valid (snoop_valid),
        .snoop_res   (snoop_res),
        .c_out       (c_out),
        .done_valid  (done_valid),
        .done_op     (done_op),
        .busy        (busy)
`ifdef CACHE_SNOOP_STATS_EN
        ,
        .busrd_cnt   (busrd_cnt),
        .busrdx_cnt  (busrdx_cnt),
        .busupgr_cnt (busupgr_cnt),
        .flush_cnt   (flush_cnt),
        .hitm_cnt    (hitm_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] addr;
        bit          hold;
        int          exp_snoops;
        int          exp_res;
        int          exp_c;
        int          exp_done;
    } vec_t;

    // Drives one request and observes it; cycle k = value seen between accept edge+k-1 and +k.
    task automatic run_txn(input logic [1:0] op, input logic [31:0] addr, input bit hold,
                           output int snoops, output int res_seen, output int c_seen,
                           output int done_cyc, output int done_op_seen, output int dones,
                           output int ready_cyc, output int bad);
        int w;
        snoops = 0; res_seen = -1; c_seen = 0; done_cyc = -1; done_op_seen = -1;
        dones = 0; ready_cyc = -1; bad = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) req_valid = 1'b0;
            if (snoop_valid) begin
                snoops++;
                res_seen = snoop_res;
                c_seen   = c_out;
            end else if (snoop_res != 2'd0 || c_out != 1'b0) begin
                bad++;
            end
            if (done_valid) begin
                dones++;
                done_cyc     = k;
                done_op_seen = done_op;
            end else if (done_op != 2'd0) begin
                bad++;
            end
            if (req_ready) begin
                ready_cyc = k;
                if (busy) bad++;
                req_valid = 1'b0;
                break;
            end else if (!busy) begin
                bad++;
            end
        end
    endtask

    task automatic apply(input vec_t v);
        int snoops, res_seen, c_seen, done_cyc, done_op_seen, dones, ready_cyc, bad;
        run_txn(v.op, v.addr, v.hold, snoops, res_seen, c_seen, done_cyc, done_op_seen,
                dones, ready_cyc, bad);
        $display("txn %s op=%0d addr=%h snoops=%0d res=%0d c=%0d done@%0d ready@%0d",
                 v.name, v.op, v.addr, snoops, res_seen, c_seen, done_cyc, ready_cyc);
        chk({v.name, "_snoop_cnt"}, snoops, v.exp_snoops);
        chk({v.name, "_res"}, res_seen, v.exp_res);
        chk({v.name, "_c"}, c_seen, v.exp_c);
        chk({v.name, "_done_cyc"}, done_cyc, v.exp_done);
        chk({v.name, "_done_op"}, done_op_seen, v.op);
        chk({v.name, "_done_cnt"}, dones, 1);
        chk({v.name, "_ready_cyc"}, ready_cyc, v.exp_done + 1);
        chk({v.name, "_pulse_busy_viol"}, bad, 0);
    endtask

    // Reference model straight from the rules: address table, op class, latency sum.
    function automatic vec_t model(input logic [1:0] op, input logic [31:0] addr);
        int res_tab [4] = '{1, 2, 0, 0};
        vec_t v;
        int lat;
        int r;
        r = res_tab[addr % 4];
        v.name = "rand";
        v.op   = op;
        v.addr = addr;
        v.hold = ($urandom_range(0, 3) == 0);
        v.exp_snoops = (op == 2'd3) ? 0 : 1;
        v.exp_res    = (op == 2'd3) ? -1 : r;
        v.exp_c      = (op != 2'd3 && r != 0) ? 1 : 0;
        if (op == 2'd2)                  lat = 0;
        else if (op != 2'd3 && r == 2)   lat = HITM_LAT;
        else                             lat = MEM_LAT;
        v.exp_done = 2 + lat;
        return v;
    endfunction

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        vecs[0] = '{"busrd_nohit",   2'd0, 32'h1000_0002, 1'b0, 1, 0, 0, 6};
        vecs[1] = '{"busrdx_hitm",   2'd1, 32'h1000_0001, 1'b0, 1, 2, 1, 4};
        vecs[2] = '{"busupgr_hold",  2'd2, 32'h2000_0000, 1'b1, 1, 1, 1, 2};
        vecs[3] = '{"flush",         2'd3, 32'h3000_0001, 1'b0, 0, -1, 0, 6};
        vecs[4] = '{"busrd_hit",     2'd0, 32'h0000_0000, 1'b1, 1, 1, 1, 6};
        vecs[5] = '{"busrdx_nohit",  2'd1, 32'h0000_0003, 1'b0, 1, 0, 0, 6};
        vecs[6] = '{"busupgr_hitm",  2'd2, 32'hABCD_0005, 1'b0, 1, 2, 1, 2};
        vecs[7] = '{"flush_a0",      2'd3, 32'h4000_0000, 1'b0, 0, -1, 0, 6};

        rstb = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_hold_ready", req_ready, 1);
        chk("rst_hold_busy", busy, 0);
        rstb = 1'b0;
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_outputs", {snoop_valid, snoop_res, c_out, done_valid, done_op, busy}, 0);

        for (int i = 0; i < 8; i++) apply(vecs[i]);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] addr;
            op   = 2'($urandom_range(0, 3));
            addr = $urandom;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            apply(model(op, addr));
        end

        // Abort a BUSRD in the middle of its WAIT interval.
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd0; req_addr = 32'h1000_0002;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midwait_busy_before_rst", busy, 1);
        rstb = 1'b1;
        #1;
        chk("midwait_rst_ready", req_ready, 1);
        chk("midwait_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rstb = 1'b0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done_valid) seen++;
        end
        $display("txn reset_abort done_pulses_after=%0d", seen);
        chk("midwait_no_done", seen, 0);
        apply(vecs[0]);

`ifdef CACHE_SNOOP_STATS_EN
        rstb = 1'b1;
        @(negedge clk);
        rstb = 1'b0;
        chk("stats_rst_busrd", busrd_cnt, 0);
        for (int i = 0; i < 3; i++) apply(vecs[0]);
        for (int i = 0; i < 2; i++) apply(vecs[1]);
        @(negedge clk);
        chk("stats_busrd", busrd_cnt, 3);
        chk("stats_busrdx", busrdx_cnt, 2);
        chk("stats_hitm", hitm_cnt, 2);
        chk("stats_busupgr", busupgr_cnt, 0);
        chk("stats_flush", flush_cnt, 0);
        force dut.gen_op_cnt[0].cnt_reg = 16'hFFFF;
        @(negedge clk);
        release dut.gen_op_cnt[0].cnt_reg;
        apply(vecs[0]);
        @(negedge clk);
        chk("stats_busrd_saturate", busrd_cnt, 16'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
